// File: rtl/tile_transpose_engine_if.sv
// Bus bundle for tile_transpose_engine.
// Macros: none.
// Signals:
//   sig_start, mode, A_m1, B_m1, O_base_addr, A_base_addr : operation request
//   data_in   : source read data (lane 0 in the LSBs)
//   O_addr, O_r_en        : source read address / enable
//   A_addr, A_w_en, data_out : destination write address / enable / data
//   busy, sig_end         : operation in progress / one-cycle completion pulse
// Modports: master = requester and memory side, slave = engine side.
interface tile_transpose_engine_if #(
  parameter int unsigned DIM        = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned CW = $clog2(DIM);

  logic                      sig_start;
  logic                      mode;
  logic [CW-1:0]             A_m1;
  logic [CW-1:0]             B_m1;
  logic [ADDR_WIDTH-1:0]     O_base_addr;
  logic [ADDR_WIDTH-1:0]     A_base_addr;
  logic [DIM*DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0]     O_addr;
  logic                      O_r_en;
  logic [ADDR_WIDTH-1:0]     A_addr;
  logic                      A_w_en;
  logic [DIM*DATA_WIDTH-1:0] data_out;
  logic                      busy;
  logic                      sig_end;

  modport master (
    output sig_start, mode, A_m1, B_m1, O_base_addr, A_base_addr, data_in,
    input  O_addr, O_r_en, A_addr, A_w_en, data_out, busy, sig_end
  );

  modport slave (
    input  sig_start, mode, A_m1, B_m1, O_base_addr, A_base_addr, data_in,
    output O_addr, O_r_en, A_addr, A_w_en, data_out, busy, sig_end
  );
endinterface

// File: rtl/tile_transpose_engine.sv
// Tile transpose / copy engine.
// Reads B rows of DIM lanes from a source buffer, holds them in a local tile,
// then writes either the transposed tile (A rows of B valid lanes) or a
// straight copy (B rows of A valid lanes) to a destination buffer.
// Optional feature macro: TRANSPOSE_RELU_EN (clamp negative written elements to 0).
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : tile_transpose_engine_if.slave (request, read and write buses)
module tile_transpose_engine #(
  parameter int unsigned DIM        = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  tile_transpose_engine_if.slave bus
);
  localparam int unsigned CW   = $clog2(DIM);
  localparam int unsigned CNTW = CW + 1;          // holds DIM itself
  localparam int unsigned PE   = CW + 1;          // pipe entry: {valid, row}
  localparam int unsigned PW   = RD_LAT * PE;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_e;
  typedef logic [DIM-1:0][DATA_WIDTH-1:0] row_t;

  state_e                          state_q, state_d;
  logic [CNTW-1:0]                 cnt_q, cnt_d;
  logic                            mode_q;
  logic [CNTW-1:0]                 a_q, b_q;
  logic [ADDR_WIDTH-1:0]           obase_q, abase_q;
  logic [DIM-1:0]                  [DIM-1:0][DATA_WIDTH-1:0] tile_q;
  logic [PW-1:0]                   pipe_q;

  logic                            accept;
  logic                            o_r_en, a_w_en, sig_end;
  logic [ADDR_WIDTH-1:0]           o_addr, a_addr;
  row_t                            dout;
  logic [CW-1:0]                   col;
  logic [CNTW-1:0]                 wr_len;
  logic [PE-1:0]                   cap;

  function automatic logic [DATA_WIDTH-1:0] post(input logic [DATA_WIDTH-1:0] e);
`ifdef TRANSPOSE_RELU_EN
    return e[DATA_WIDTH-1] ? '0 : e;
`else
    return e;
`endif
  endfunction

  // Oldest pipe entry: the read issued RD_LAT cycles ago, returning now.
  assign cap = pipe_q[PW-1 -: PE];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    o_r_en  = 1'b0;
    a_w_en  = 1'b0;
    sig_end = 1'b0;
    o_addr  = '0;
    a_addr  = '0;
    dout    = '0;
    col     = cnt_q[CW-1:0];
    wr_len  = mode_q ? b_q : a_q;
    unique case (state_q)
      IDLE: begin
        if (bus.sig_start) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        o_r_en = 1'b1;
        o_addr = obase_q + ADDR_WIDTH'(cnt_q);
        if (cnt_q == b_q - CNTW'(1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNTW'(RD_LAT - 1)) begin
          cnt_d   = '0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      WRITE: begin
        a_w_en = 1'b1;
        a_addr = abase_q + ADDR_WIDTH'(cnt_q);
        for (int unsigned i = 0; i < DIM; i++) begin
          if (mode_q) begin
            if (CNTW'(i) < a_q) dout[CW'(i)] = post(tile_q[col][CW'(i)]);
          end else begin
            if (CNTW'(i) < b_q) dout[CW'(i)] = post(tile_q[CW'(i)][col]);
          end
        end
        if (cnt_q == wr_len - CNTW'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        sig_end = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      obase_q <= '0;
      abase_q <= '0;
      tile_q  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mode_q  <= bus.mode;
        a_q     <= CNTW'(bus.A_m1) + CNTW'(1);
        b_q     <= CNTW'(bus.B_m1) + CNTW'(1);
        obase_q <= bus.O_base_addr;
        abase_q <= bus.A_base_addr;
      end
      // Shift in the new entry; the cast drops the entry that is consumed
      // this cycle, which also covers RD_LAT == 1 without a special case.
      pipe_q <= PW'({pipe_q, o_r_en, cnt_q[CW-1:0]});
      if (cap[PE-1]) tile_q[cap[CW-1:0]] <= bus.data_in;
    end
  end

  assign bus.O_r_en   = o_r_en;
  assign bus.O_addr   = o_addr;
  assign bus.A_w_en   = a_w_en;
  assign bus.A_addr   = a_addr;
  assign bus.data_out = dout;
  assign bus.sig_end  = sig_end;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: doc/tile_transpose_engine.md
TILE_TRANSPOSE_ENGINE -- requirements
Module: tile_transpose_engine

Interface
REQ-001 The block SHALL have parameter DIM, default 16, giving tile lanes per row and maximum rows.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving element width in bits.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 10, giving buffer address width.
REQ-004 The block SHALL have parameter RD_LAT, default 1 (legal 1..4), giving output-buffer read latency in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port sig_start, input, 1 bit: start request.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = transpose, 1 = copy.
REQ-009 The block SHALL have port A_m1, input, $clog2(DIM) bits: output columns minus 1.
REQ-010 The block SHALL have port B_m1, input, $clog2(DIM) bits: output rows minus 1.
REQ-011 The block SHALL have ports O_base_addr and A_base_addr, input, ADDR_WIDTH bits each: source and destination base addresses.
REQ-012 The block SHALL have port data_in, input, DIM*DATA_WIDTH bits: read data, with lane 0 in the LSBs.
REQ-013 The block SHALL have ports O_addr (ADDR_WIDTH) and O_r_en (1), both outputs: source read address and read enable.
REQ-014 The block SHALL have ports A_addr (ADDR_WIDTH), A_w_en (1) and data_out (DIM*DATA_WIDTH), all outputs: destination write address, write enable and write data.
REQ-015 The block SHALL have ports busy and sig_end, outputs, 1 bit each: operation in progress, and a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, READ, DRAIN, WRITE and DONE.
REQ-017 In IDLE, sig_start=1 SHALL latch mode, A=A_m1+1, B=B_m1+1 and both base addresses, then enter READ.
REQ-018 sig_start SHALL be ignored in every state except IDLE.
REQ-019 READ SHALL last B cycles, driving O_r_en=1 and O_addr=O_base_addr+r for r=0..B-1.
REQ-020 data_in SHALL be captured into tile row r exactly RD_LAT cycles after the cycle that issued address r.
REQ-021 DRAIN SHALL last RD_LAT cycles with O_r_en=0, then enter WRITE.
REQ-022 In transpose mode, WRITE SHALL last A cycles; cycle j drives A_w_en=1, A_addr=A_base_addr+j, and data_out lane i = tile[i][j] for i<B, 0 for i>=B.
REQ-023 In copy mode, WRITE SHALL last B cycles; cycle r drives A_addr=A_base_addr+r, and data_out lane i = tile[r][i] for i<A, 0 for i>=A.
REQ-024 DONE SHALL last one cycle with sig_end=1, then return to IDLE.
REQ-025 busy SHALL be 1 in READ, DRAIN, WRITE and DONE, and 0 in IDLE.
REQ-026 Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-027 Outside their active states, O_r_en, A_w_en and sig_end SHALL be 0, and O_addr, A_addr and data_out SHALL be 0.
REQ-028 A_m1=B_m1=0 (a 1x1 tile) SHALL complete in 1+RD_LAT+1+1 cycles after start.
REQ-029 A=B=DIM SHALL be supported without overflow of the internal counters.
REQ-030 A sig_start held high through DONE SHALL begin a new operation from the first IDLE cycle.

Reset
REQ-031 Asserting reset at any time, including mid-operation, SHALL immediately force IDLE and drive every output and the tile storage to 0.
REQ-032 After reset, sig_end SHALL NOT be generated for an aborted operation.

Configuration
REQ-033 With macro TRANSPOSE_RELU_EN defined, each element written by WRITE SHALL be treated as signed two's complement, with negative values replaced by 0.
REQ-034 Without TRANSPOSE_RELU_EN, elements SHALL pass unmodified, and no ReLU logic SHALL be synthesised.

Verification
REQ-035 Transpose: DIM=16, RD_LAT=1, A_m1=9, B_m1=7, O_base=100, A_base=200, row r lane i = r*16+i -> writes to addresses 200..209, row j lane i = i*16+j for i<8 and 0 otherwise; sig_end in cycle 20 after the start edge.
REQ-036 Copy: same stimulus with mode=1 -> 8 writes to addresses 200..207, lanes 10..15 zero, data otherwise equal to input.
REQ-037 Latency: RD_LAT=3, A_m1=B_m1=0 -> O_r_en high for 1 cycle, 3 DRAIN cycles, 1 write, sig_end in cycle 6.
REQ-038 Wrap/full: A_m1=B_m1=15, O_base=1020, A_base=1023 -> read addresses 1020..1023 then 0..11, write addresses 1023 then 0..14.
REQ-039 Reset mid-WRITE -> all outputs 0 in the same cycle, no sig_end, and a new start is accepted after reset is released.
REQ-040 ReLU: with TRANSPOSE_RELU_EN, input element 8'hF0 -> output 8'h00; without it -> output 8'hF0.
